uart_receiver: RTL

- Serial-to-parallel UART receiver; the receive end of the link driven by uart_transmitter.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 or 2 stop bits (1). Idle line is high.
- Synchronises `serial_in`, samples each bit mid-period, and presents the received byte on a valid/ready handshake.
- Flags framing and overrun errors to the CPU-side UART register logic.

---
 rtl/uart_receiver.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//   Serial-to-parallel UART receiver. Frame: 1 start bit (0), 8 data bits
//   LSB first, 1 or 2 stop bits (1); the line idles high. The line is
//   synchronised, each bit is sampled mid-period, and the received byte is
//   offered on a valid/ready handshake. Framing and overrun errors are
//   reported as sticky flags.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (4 or more)
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous, active-high reset
//   serial_in    in   asynchronous serial line
//   stop_2       in   1 = two stop bits expected (latched at start acceptance)
//   rx_ready     in   consumer takes data_out when high with byte_valid
//   err_clr      in   one-cycle pulse, clears both sticky error flags
//   data_out     out  last received byte
//   byte_valid   out  data_out holds an unconsumed byte
//   framing_err  out  sticky, a stop bit was sampled 0
//   overrun_err  out  sticky, a byte completed while the previous was unconsumed
//   busy         out  high in every state except IDLE
//   bit_cnt_out  out  data bits received in the current frame (0..8)
// -----------------------------------------------------------------------------
module uart_receiver #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  input  logic       stop_2,
  input  logic       rx_ready,
  input  logic       err_clr,
  output logic [7:0] data_out,
  output logic       byte_valid,
  output logic       framing_err,
  output logic       overrun_err,
  output logic       busy,
  output logic [3:0] bit_cnt_out
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP1,
    STOP2
  } state_t;

  state_t           state;
  logic             sync1;
  logic             rx_s;
  logic             rx_prev;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       shift;
  logic             stop2_q;

  logic fall;
  logic bit_tick;
  logic in_stop;
  logic complete;
  logic stop_bad;

  assign fall     = rx_prev & ~rx_s;
  assign bit_tick = (cnt == BIT_LAST);
  assign in_stop  = (state == STOP1) || (state == STOP2);
  // A good stop bit ends the frame unless a second stop bit is still due.
  assign complete = bit_tick && rx_s &&
                    ((state == STOP2) || ((state == STOP1) && !stop2_q));
  assign stop_bad = bit_tick && !rx_s && in_stop;

  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; later assignments in the block override earlier
  // ones, which is how "set wins over clear" is expressed below.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sync1       <= 1'b1;
      rx_s        <= 1'b1;
      rx_prev     <= 1'b1;
      cnt         <= '0;
      shift       <= '0;
      stop2_q     <= 1'b0;
      data_out    <= '0;
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
      busy        <= 1'b0;
      bit_cnt_out <= '0;
    end else begin
      sync1   <= serial_in;
      rx_s    <= sync1;
      rx_prev <= rx_s;

      if (err_clr) begin
        framing_err <= 1'b0;
        overrun_err <= 1'b0;
      end

      if (byte_valid && rx_ready) begin
        byte_valid <= 1'b0;
      end

      if (complete) begin
        if (byte_valid && !rx_ready) begin
          overrun_err <= 1'b1;
        end else begin
          data_out   <= shift;
          byte_valid <= 1'b1;
        end
      end

      if (stop_bad) begin
        framing_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (fall) begin
            cnt     <= '0;
            stop2_q <= stop_2;
            state   <= START;
            busy    <= 1'b1;
          end
        end

        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              bit_cnt_out <= '0;
              state       <= DATA;
            end else begin
              // Line back high at mid start bit: treat as a glitch.
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (bit_tick) begin
            cnt         <= '0;
            shift       <= {rx_s, shift[7:1]};
            bit_cnt_out <= bit_cnt_out + 4'd1;
            if (bit_cnt_out == 4'd7) begin
              state <= STOP1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        STOP1: begin
          if (bit_tick) begin
            cnt <= '0;
            if (rx_s && stop2_q) begin
              state <= STOP2;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        STOP2: begin
          if (bit_tick) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
